// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the CHARIS-style 32-bit processor.
// Sequences IF -> DEC -> EXEC -> [MEM] -> [WB] one instruction at a time,
// driving fetch (PC/IR) and datapath controls. All outputs are gated by Reset.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        MEM_Ready,
  output logic        PC_Sel,
  output logic        PC_LdEn,
  output logic        IR_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [1:0]  ImmExt,
  output logic [3:0]  ALU_func,
  output logic        MEM_WrEn,
  output logic        ByteOp,
  output logic        Illegal,
  output logic [2:0]  State
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Counter value seen during the last tolerated stalled MEM cycle.
  localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_DEC  = 3'd1,
    S_EXEC = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_LI, C_LUI, C_ADDI, C_ANDI, C_ORI,
    C_B, C_BEQ, C_BNE, C_LB, C_LW, C_SB, C_SW, C_BAD
  } cls_t;

  state_t         state_q, state_d;
  logic [5:0]     op_q;
  logic [3:0]     func_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  cls_t           cls;

  // Bits of the instruction word this block never looks at.
  logic unused_instr;
  assign unused_instr = ^Instr[25:4];

  // Decoded per-instruction attributes.
  logic       is_branch, is_load, is_store, is_byte;
  logic [3:0] dec_func;
  logic       dec_bin, dec_bsel;
  logic [1:0] dec_imm;

  // Combinational outputs before reset gating.
  logic       pc_sel_c, pc_ld_c, ir_ld_c, rf_wr_c, wdsel_c, bsel_c, bin_c;
  logic [1:0] imm_c;
  logic [3:0] func_c;
  logic       mem_wr_c, byte_c, illegal_c;

  // State, latched opcode/func and MEM stall counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      func_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IF) begin
        op_q   <= Instr[31:26];
        func_q <= Instr[3:0];
      end
    end
  end

  // Opcode classification and the static datapath controls it implies.
  always_comb begin
    cls = C_BAD;
    case (op_q)
      6'b100000: cls = C_R;
      6'b111000: cls = C_LI;
      6'b111001: cls = C_LUI;
      6'b110000: cls = C_ADDI;
      6'b110010: cls = C_ANDI;
      6'b110011: cls = C_ORI;
      6'b111111: cls = C_B;
      6'b000000: cls = C_BEQ;
      6'b000001: cls = C_BNE;
      6'b000011: cls = C_LB;
      6'b001111: cls = C_LW;
      6'b000111: cls = C_SB;
      6'b011111: cls = C_SW;
      default:   cls = C_BAD;
    endcase
    is_branch = (cls == C_B) || (cls == C_BEQ) || (cls == C_BNE);
    is_load   = (cls == C_LB) || (cls == C_LW);
    is_store  = (cls == C_SB) || (cls == C_SW);
    is_byte   = (cls == C_LB) || (cls == C_SB);
    dec_bin   = is_load || is_store || (cls == C_LI) || (cls == C_LUI) ||
                (cls == C_ADDI) || (cls == C_ANDI) || (cls == C_ORI);
    dec_bsel  = is_store || (cls == C_BEQ) || (cls == C_BNE);
    dec_imm   = 2'b00;
    if ((cls == C_ANDI) || (cls == C_ORI)) dec_imm = 2'b01;
    else if (cls == C_LUI)                 dec_imm = 2'b10;
    else if (is_branch)                    dec_imm = 2'b11;
    dec_func = 4'b0000;
    case (cls)
      C_R:          dec_func = func_q;
      C_ANDI:       dec_func = 4'b0010;
      C_ORI:        dec_func = 4'b0011;
      C_BEQ, C_BNE: dec_func = 4'b0001;
      default:      dec_func = 4'b0000;
    endcase
  end

  // Next-state and per-cycle control outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_sel_c  = 1'b0;
    pc_ld_c   = 1'b0;
    ir_ld_c   = 1'b0;
    rf_wr_c   = 1'b0;
    wdsel_c   = 1'b0;
    bsel_c    = 1'b0;
    bin_c     = 1'b0;
    imm_c     = 2'b00;
    func_c    = 4'b0000;
    mem_wr_c  = 1'b0;
    byte_c    = 1'b0;
    illegal_c = 1'b0;

    // Static controls held from DEC onward so they stay stable across stalls.
    if (state_q != S_IF && cls != C_BAD) begin
      bsel_c = dec_bsel;
      bin_c  = dec_bin;
      imm_c  = dec_imm;
      func_c = dec_func;
    end

    case (state_q)
      S_IF: begin
        ir_ld_c = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (cls == C_BAD) begin
          pc_ld_c   = 1'b1;
          illegal_c = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_ld_c  = 1'b1;
          pc_sel_c = (cls == C_B) ? 1'b1 : (cls == C_BEQ) ? ALU_zero : ~ALU_zero;
          state_d  = S_IF;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_wr_c = is_store;
        byte_c   = is_byte;
        if (MEM_Ready) begin
          cnt_d = '0;
          if (is_store) begin
            pc_ld_c = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (MEM_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          // Abandon the access: skip the instruction like a NOP.
          illegal_c = 1'b1;
          pc_ld_c   = 1'b1;
          cnt_d     = '0;
          state_d   = S_IF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        rf_wr_c = 1'b1;
        pc_ld_c = 1'b1;
        wdsel_c = is_load;
        byte_c  = is_byte;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign PC_Sel        = pc_sel_c  & ~Reset;
  assign PC_LdEn       = pc_ld_c   & ~Reset;
  assign IR_LdEn       = ir_ld_c   & ~Reset;
  assign RF_WrEn       = rf_wr_c   & ~Reset;
  assign RF_WrData_sel = wdsel_c   & ~Reset;
  assign RF_B_sel      = bsel_c    & ~Reset;
  assign ALU_Bin_sel   = bin_c     & ~Reset;
  assign ImmExt        = Reset ? 2'b00   : imm_c;
  assign ALU_func      = Reset ? 4'b0000 : func_c;
  assign MEM_WrEn      = mem_wr_c  & ~Reset;
  assign ByteOp        = byte_c    & ~Reset;
  assign Illegal       = illegal_c & ~Reset;
  assign State         = Reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (MEM_TIMEOUT=8).
// A per-instruction reference trace is built from the opcode table and
// the path rules, then compared cycle by cycle against the DUT outputs.
module tb_multicycle_control;

  localparam int TMO = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr = 32'h8000_0000;
  logic        ALU_zero = 1'b0;
  logic        MEM_Ready = 1'b0;
  logic        PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic        ALU_Bin_sel, MEM_WrEn, ByteOp, Illegal;
  logic [1:0]  ImmExt;
  logic [3:0]  ALU_func;
  logic [2:0]  State;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
    .MEM_Ready(MEM_Ready), .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn),
    .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ImmExt(ImmExt),
    .ALU_func(ALU_func), .MEM_WrEn(MEM_WrEn), .ByteOp(ByteOp),
    .Illegal(Illegal), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_sel, pc_ld, ir_ld, rf_wr, wdsel, bsel, binsel;
    logic [1:0] imm;
    logic [3:0] fn;
    logic       mem_wr, byteop, illegal;
  } out_t;

  typedef struct packed {
    out_t o;
    logic rdy;
  } ent_t;

  out_t got;
  assign got = {State, PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel,
                RF_B_sel, ALU_Bin_sel, ImmExt, ALU_func, MEM_WrEn, ByteOp, Illegal};

  ent_t tr[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void push(input out_t o, input logic r);
    tr.push_back({o, r});
  endfunction

  // Expected cycle-by-cycle trace of one instruction.
  // stall = number of MEM cycles with MEM_Ready low before it rises.
  function automatic void build(input logic [31:0] ins, input logic zero, input int stall);
    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3;
    logic [5:0] op;
    out_t b, e;
    int   kind;
    logic known, byt, taken;
    op = ins[31:26];
    b = '0; kind = K_ALU; known = 1'b1; byt = 1'b0; taken = 1'b0;
    case (op)
      6'b100000: b.fn = ins[3:0];
      6'b111000, 6'b110000: b.binsel = 1'b1;
      6'b111001: begin b.binsel = 1'b1; b.imm = 2'b10; end
      6'b110010: begin b.binsel = 1'b1; b.imm = 2'b01; b.fn = 4'b0010; end
      6'b110011: begin b.binsel = 1'b1; b.imm = 2'b01; b.fn = 4'b0011; end
      6'b111111: begin kind = K_BR; b.imm = 2'b11; taken = 1'b1; end
      6'b000000: begin kind = K_BR; b.imm = 2'b11; b.fn = 4'b0001; b.bsel = 1'b1; taken = zero; end
      6'b000001: begin kind = K_BR; b.imm = 2'b11; b.fn = 4'b0001; b.bsel = 1'b1; taken = ~zero; end
      6'b000011: begin kind = K_LD; b.binsel = 1'b1; byt = 1'b1; end
      6'b001111: begin kind = K_LD; b.binsel = 1'b1; end
      6'b000111: begin kind = K_ST; b.binsel = 1'b1; b.bsel = 1'b1; byt = 1'b1; end
      6'b011111: begin kind = K_ST; b.binsel = 1'b1; b.bsel = 1'b1; end
      default:   known = 1'b0;
    endcase
    tr.delete();
    e = '0; e.st = 3'd0; e.ir_ld = 1'b1; push(e, 1'($urandom));
    if (!known) begin
      e = '0; e.st = 3'd1; e.pc_ld = 1'b1; e.illegal = 1'b1; push(e, 1'($urandom));
      return;
    end
    e = b; e.st = 3'd1; push(e, 1'($urandom));
    e = b; e.st = 3'd2;
    if (kind == K_BR) begin
      e.pc_ld = 1'b1; e.pc_sel = taken; push(e, 1'($urandom));
      return;
    end
    push(e, 1'($urandom));
    if (kind == K_ALU) begin
      e = b; e.st = 3'd4; e.rf_wr = 1'b1; e.pc_ld = 1'b1; push(e, 1'($urandom));
      return;
    end
    for (int k = 0; k <= stall; k++) begin
      e = b; e.st = 3'd3; e.mem_wr = (kind == K_ST); e.byteop = byt;
      if (k < stall) begin
        if (k == TMO - 1) begin
          e.illegal = 1'b1; e.pc_ld = 1'b1; push(e, 1'b0);
          return;
        end
        push(e, 1'b0);
      end else begin
        e.pc_ld = (kind == K_ST); push(e, 1'b1);
      end
    end
    if (kind == K_LD) begin
      e = b; e.st = 3'd4; e.rf_wr = 1'b1; e.pc_ld = 1'b1; e.wdsel = 1'b1; e.byteop = byt;
      push(e, 1'($urandom));
    end
  endfunction

  task automatic check(input string tag, input int i, input out_t e);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s[%0d] got=%h exp=%h", tag, i, got, e);
    end
  endtask

  // Entered just after a rising edge at the start of an IF cycle.
  task automatic run(input logic [31:0] ins, input logic zero, input int stall,
                     input string tag, input int ncyc = 1000);
    build(ins, zero, stall);
    Instr = ins;
    ALU_zero = zero;
    for (int i = 0; i < tr.size() && i < ncyc; i++) begin
      MEM_Ready = tr[i].rdy;
      #1;
      check(tag, i, tr[i].o);
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  ops [14];
    logic [5:0]  op;
    logic [31:0] ins;
    out_t        e;
    ops = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
            6'b111111, 6'b000000, 6'b000001, 6'b000011, 6'b001111, 6'b000111,
            6'b011111, 6'b101010};

    // Reset held three cycles: every output low.
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #2;
      check("reset", c, '0);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    run(32'h8000_0000, 1'b0, 0, "add");

    run({6'b000000, 26'h0123456}, 1'b1, 0, "beq_t");
    run({6'b000000, 26'h0123456}, 1'b0, 0, "beq_nt");
    run({6'b000001, 26'h0000010}, 1'b0, 0, "bne_t");
    run({6'b111111, 26'h3ffffff}, 1'b0, 0, "b");
    run({6'b001111, 26'h0aaaaaa}, 1'b0, 4, "lw_stall4");
    run({6'b000111, 26'h0155555}, 1'b1, 0, "sb");
    run({6'b101010, 26'h0000000}, 1'b0, 0, "illegal_op");
    run({6'b100000, 22'h0, 4'b0001}, 1'b0, 0, "sub");
    run({6'b110010, 26'h000ffff}, 1'b0, 0, "andi");
    run({6'b111001, 26'h0001234}, 1'b0, 0, "lui");

    // Reset arrives asynchronously in the middle of a stalled sw MEM cycle.
    run({6'b011111, 26'h0000040}, 1'b0, 5, "sw_pre", 5);
    MEM_Ready = 1'b0;
    #1;
    check("sw_mem", 5, tr[5].o);
    #2;
    Reset = 1'b1;
    #1;
    check("sw_rst_async", 0, '0);
    MEM_Ready = 1'b1;
    @(posedge Clk); #2;
    check("sw_rst_held", 1, '0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    run(32'h8000_0003, 1'b0, 0, "post_reset_or");

    // MEM_Ready stuck low: Illegal on the 8th stalled cycle, then IF.
    run({6'b001111, 26'h0000004}, 1'b0, 20, "lw_timeout");
    run({6'b000111, 26'h0000004}, 1'b0, TMO, "sb_timeout");
    run({6'b000011, 26'h0000004}, 1'b0, TMO - 1, "lb_stall7");

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      ins = {op, 26'($urandom)};
      run(ins, 1'($urandom), int'($urandom_range(0, 10)), "rand");
    end

    // One cycle more to confirm the last instruction returned to IF.
    e = '0; e.ir_ld = 1'b1;
    MEM_Ready = 1'b0;
    #1;
    check("final_if", 0, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences the instruction fetch stage and the downstream datapath (decode/register file, ALU, data memory, writeback) for the CHARIS-style 32-bit processor.
- Drives the fetch stage's PC_Sel/PC_LdEn, the instruction-register load, and all datapath mux/enable/ALU-function controls, one instruction at a time.
- Stalls in the memory state on a data-memory ready handshake.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles spent in MEM waiting for MEM_Ready before Illegal is pulsed and the instruction is abandoned; 0 disables the timeout.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Instr  input  32  instruction word from the fetch stage for the current PC
- ALU_zero  input  1  ALU zero flag, combinational, valid in EXEC
- MEM_Ready  input  1  data memory has completed the access this cycle
- PC_Sel  output  1  0 = PC+4, 1 = PC+4+branch offset
- PC_LdEn  output  1  PC load enable
- IR_LdEn  output  1  instruction-register load
- RF_WrEn  output  1  register file write enable
- RF_WrData_sel  output  1  0 = ALU result, 1 = memory data
- RF_B_sel  output  1  0 = Instr[15:11], 1 = Instr[20:16]
- ALU_Bin_sel  output  1  0 = RF B operand, 1 = extended immediate
- ImmExt  output  2  00 sign-extend, 01 zero-extend, 10 <<16, 11 sign-extend<<2
- ALU_func  output  4  0000 add, 0001 sub, 0010 and, 0011 or; R-type passes func
- MEM_WrEn  output  1  data memory write
- ByteOp  output  1  byte access (lb/sb)
- Illegal  output  1  one-cycle pulse: unknown opcode or MEM timeout
- State  output  3  IF=0, DEC=1, EXEC=2, MEM=3, WB=4

Behaviour:
- Reset high, asynchronous:
  - state to IF; latched opcode/func to 0; timeout counter to 0.
  - All outputs forced to 0, including IR_LdEn and State; the outputs are gated by Reset.
  - The first active IF cycle is the first cycle after Reset deasserts.
  - Reset mid-instruction abandons it; no PC/RF/MEM write occurs during or after reset in that instruction.
- IF (1 cycle):
  - IR_LdEn=1.
  - Capture Instr[31:26] and Instr[3:0] at the rising edge; go to DEC.
- DEC:
  - Decode the latched opcode.
  - Known opcode: go to EXEC.
  - Unknown opcode: PC_LdEn=1, PC_Sel=0, Illegal=1, go to IF (executes as NOP, 2 cycles).
- Opcode table:
  - 100000 R-type: func = latched Instr[3:0].
  - 111000 li, 111001 lui, 110000 addi, 110010 andi, 110011 ori.
  - 111111 b, 000000 beq, 000001 bne.
  - 000011 lb, 001111 lw, 000111 sb, 011111 sw.
- ALU_func:
  - add for addi/li/lui/loads/stores.
  - and for andi, or for ori, sub for beq/bne.
- ALU_Bin_sel=1 for all immediate forms and loads/stores; 0 for R-type/beq/bne.
- ImmExt:
  - 01 for andi/ori.
  - 10 for lui.
  - 11 for b/beq/bne.
  - 00 otherwise.
- RF_B_sel=1 for stores and beq/bne.
- Paths, with PC_LdEn asserted in exactly one cycle per instruction (the last):
  - ALU/immediate: IF, DEC, EXEC, WB. RF_WrEn=1 and PC_LdEn=1 in WB. 4 cycles.
  - Branch: IF, DEC, EXEC. PC_LdEn=1 in EXEC. PC_Sel = 1 for b, ALU_zero for beq, !ALU_zero for bne. 3 cycles.
  - Load: IF, DEC, EXEC, MEM (held until MEM_Ready), WB. RF_WrData_sel=1, RF_WrEn=1 and PC_LdEn=1 in WB.
  - Store: IF, DEC, EXEC, MEM. MEM_WrEn=1 in every MEM cycle. PC_LdEn=1 only in the MEM cycle where MEM_Ready=1.
- ByteOp=1 in MEM and WB for lb/sb; control outputs stay stable throughout MEM stalls.
- MEM timeout:
  - The counter increments each MEM cycle with MEM_Ready=0.
  - On reaching MEM_TIMEOUT: Illegal=1, PC_LdEn=1, PC_Sel=0, no RF write, go to IF.
  - The counter clears on leaving MEM.
- PC_Sel=0 whenever PC_LdEn=0.
- RF_WrEn is never asserted outside WB; MEM_WrEn is never asserted outside MEM.

Test Plan:
- Reset held 3 cycles then released with Instr=R-type add (0x80000000 | func 0000) → all outputs 0 during reset. Then State 0,1,2,4; RF_WrEn=1 and PC_LdEn=1 only in the WB cycle; ALU_func=0000.
- beq (opcode 000000) with ALU_zero=1, then again with ALU_zero=0 → 3-cycle sequence each time. PC_LdEn=1 in EXEC; PC_Sel=1 first, 0 second; ImmExt=11; ALU_func=0001.
- lw with MEM_Ready low for 4 cycles then high → MEM held 5 cycles with stable outputs. WB follows with RF_WrData_sel=1, RF_WrEn=1, PC_LdEn=1.
- sb with MEM_Ready=1 immediately → 4 cycles. MEM_WrEn=1, ByteOp=1 and PC_LdEn=1 in MEM; RF_WrEn never asserted.
- Opcode 101010 → Illegal pulse plus PC_LdEn=1, PC_Sel=0 in DEC; next cycle State=IF.
- Reset asserted mid-MEM of sw, asynchronously between edges → outputs drop to 0 immediately, no MEM_WrEn or PC_LdEn afterwards, State=IF. Separately, MEM_TIMEOUT=8 with MEM_Ready stuck low → Illegal on the 8th stalled cycle, then IF.
